pingpong_counter: RTL and testbench

Parametrised up/down/ping-pong counter with configurable width and count range. Drives the counter value, a registered direction bit, an upper-half flag and a terminal-count strobe. Supports synchronous load and per-cycle enable. Used as the general counter primitive for display scanning, PWM ramps and sequencing in lab designs.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_clamp.sv | 24 ++
 rtl/pingpong_counter.sv | 124 ++++++++++++
 tb/tb_pingpong_counter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the pingpong_counter primitive and its helpers.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  localparam int WRAPCNT_W = 8;

endpackage

// File: rtl/counter_clamp.sv
// Combinational saturating clamp of a WIDTH-bit value into [MIN, MAX].
module counter_clamp #(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] clamped
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Inclusive compares so neither test folds to a constant when MIN=0 or MAX is all-ones.
  always_comb begin
    if (value <= MIN_V)
      clamped = MIN_V;
    else if (value >= MAX_V)
      clamped = MAX_V;
    else
      clamped = value;
  end

endmodule

// File: rtl/pingpong_counter.sv
// Up/down/ping-pong counter over [MIN, MAX] with load, enable, direction, upper-half flag and tc strobe.
// Define PINGPONG_COUNTER_WRAPCNT_EN to add the saturating 'wraps' boundary-crossing counter output.
module pingpong_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] Q,
  output logic             dir,
  output logic             upper,
  output logic             tc
`ifdef PINGPONG_COUNTER_WRAPCNT_EN
  ,
  output logic [WRAPCNT_W-1:0] wraps
`endif
);

  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MINP1_V = WIDTH'(MIN + 1);
  localparam logic [WIDTH-1:0] MAXM1_V = WIDTH'(MAX - 1);
  localparam logic [WIDTH-1:0] MID_V   = WIDTH'((MIN + MAX + 1) / 2);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  mode_e            mode_m;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_nxt;
  logic             dir_nxt;
  logic             eff_dir;

  assign mode_m = mode_e'(mode);

  counter_clamp #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX)
  ) u_clamp (
    .value   (load_value),
    .clamped (load_clamped)
  );

  always_comb begin
    q_nxt   = Q;
    dir_nxt = dir;
    eff_dir = dir;
    case (mode_m)
      MODE_UP:   eff_dir = 1'b1;
      MODE_DOWN: eff_dir = 1'b0;
      default:   eff_dir = dir;
    endcase

    if (load) begin
      q_nxt = load_clamped;
    end else if (en) begin
      case (mode_m)
        MODE_UP: begin
          q_nxt   = (Q >= MAX_V) ? MIN_V : Q + ONE_V;
          dir_nxt = 1'b1;
        end
        MODE_DOWN: begin
          q_nxt   = (Q <= MIN_V) ? MAX_V : Q - ONE_V;
          dir_nxt = 1'b0;
        end
        MODE_PINGPONG: begin
          // Reflect off the bound in one step: no dwell cycle at MIN or MAX.
          if (dir) begin
            if (Q >= MAX_V) begin
              q_nxt   = MAXM1_V;
              dir_nxt = 1'b0;
            end else begin
              q_nxt = Q + ONE_V;
            end
          end else begin
            if (Q <= MIN_V) begin
              q_nxt   = MINP1_V;
              dir_nxt = 1'b1;
            end else begin
              q_nxt = Q - ONE_V;
            end
          end
        end
        default: begin
          q_nxt   = Q;
          dir_nxt = dir;
        end
      endcase
    end
  end

  assign tc = en & ~load & (mode_m != MODE_HOLD) &
              ((eff_dir & (Q == MAX_V)) | (~eff_dir & (Q == MIN_V)));

  assign upper = (Q >= MID_V);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q   <= MIN_V;
      dir <= 1'b1;
    end else begin
      Q   <= q_nxt;
      dir <= dir_nxt;
    end
  end

`ifdef PINGPONG_COUNTER_WRAPCNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wraps <= '0;
    else if (load)
      wraps <= '0;
    else if (tc && (wraps != '1))
      wraps <= wraps + WRAPCNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pingpong_counter.sv
// Self-checking bench for pingpong_counter: two instances (defaults, and WIDTH=5 MIN=3 MAX=12)
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_pingpong_counter;

  logic       clock;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] lv0;
  logic [4:0] lv1;
  logic [3:0] q0;
  logic [4:0] q1;
  logic       dir0, dir1, upper0, upper1, tc0, tc1;
`ifdef PINGPONG_COUNTER_WRAPCNT_EN
  logic [7:0] wraps0, wraps1;
`endif

  int passed = 0;
  int total  = 0;

  int mn_a[2] = '{0, 3};
  int mx_a[2] = '{15, 12};
  int m_q[2];
  int m_dir[2];
  int m_w[2];

  pingpong_counter #(.WIDTH(4)) dut0 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .load(load), .load_value(lv0),
    .Q(q0), .dir(dir0), .upper(upper0), .tc(tc0)
`ifdef PINGPONG_COUNTER_WRAPCNT_EN
    , .wraps(wraps0)
`endif
  );

  pingpong_counter #(.WIDTH(5), .MIN(3), .MAX(12)) dut1 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .load(load), .load_value(lv1),
    .Q(q1), .dir(dir1), .upper(upper1), .tc(tc1)
`ifdef PINGPONG_COUNTER_WRAPCNT_EN
    , .wraps(wraps1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Step direction the counter would take this cycle: +1 or -1.
  function automatic int step_dir(input int k);
    if (mode == 2'b00) return 1;
    if (mode == 2'b01) return -1;
    return (m_dir[k] != 0) ? 1 : -1;
  endfunction

  // A terminal count is simply "the step about to happen leaves the range".
  function automatic int model_tc(input int k);
    int nq;
    if (!en || load || mode == 2'b11) return 0;
    nq = m_q[k] + step_dir(k);
    return (nq > mx_a[k] || nq < mn_a[k]) ? 1 : 0;
  endfunction

  function automatic int model_upper(input int k);
    return (m_q[k] >= (mn_a[k] + mx_a[k] + 1) / 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = mn_a[k];
      m_dir[k] = 1;
      m_w[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int lv);
    int mn, mx, span, d, nq;
    mn = mn_a[k];
    mx = mx_a[k];
    span = mx - mn + 1;
    if (load) begin
      m_q[k] = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
      m_w[k] = 0;
    end else if (en && mode != 2'b11) begin
      if (model_tc(k) != 0 && m_w[k] < 255) m_w[k]++;
      d = step_dir(k);
      if (mode == 2'b10) begin
        nq = m_q[k] + d;
        if (nq > mx) begin nq = 2 * mx - nq; m_dir[k] = 0; end
        else if (nq < mn) begin nq = 2 * mn - nq; m_dir[k] = 1; end
        m_q[k] = nq;
      end else begin
        m_q[k] = mn + ((m_q[k] - mn + d + span) % span);
        m_dir[k] = (d > 0) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_model();
    check("m0_q", int'(q0), m_q[0]);
    check("m0_dir", int'(dir0), m_dir[0]);
    check("m0_upper", int'(upper0), model_upper(0));
    check("m0_tc", int'(tc0), model_tc(0));
    check("m1_q", int'(q1), m_q[1]);
    check("m1_dir", int'(dir1), m_dir[1]);
    check("m1_upper", int'(upper1), model_upper(1));
    check("m1_tc", int'(tc1), model_tc(1));
`ifdef PINGPONG_COUNTER_WRAPCNT_EN
    check("m0_wraps", int'(wraps0), m_w[0]);
    check("m1_wraps", int'(wraps1), m_w[1]);
`endif
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clock);
    model_step(0, int'(lv0));
    model_step(1, int'(lv1));
    @(negedge clock);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic set_in(input logic e, input logic [1:0] md, input logic ld, input int v0, input int v1);
    en = e; mode = md; load = ld; lv0 = 4'(v0); lv1 = 5'(v1);
  endtask

  int pp;

  initial begin
    reset = 1'b0;
    set_in(1'b1, 2'b01, 1'b0, 0, 0);
    #1 reset = 1'b1;
    model_reset();
    #2;
    check("rst_q0", int'(q0), 0);
    check("rst_dir0", int'(dir0), 1);
    check("rst_upper0", int'(upper0), 0);
    check("rst_tc0_down", int'(tc0), 1);
    check("rst_q1", int'(q1), 3);
    check("rst_tc1_down", int'(tc1), 1);
    compare_model();
    @(negedge clock);
    reset = 1'b0;

    // Ping-pong over the full 4-bit range: 0..15, 14..0, 1
    set_in(1'b1, 2'b10, 1'b0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      pp = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
      settle();
      check("pp_q0", int'(q0), pp);
      check("pp_dir0", int'(dir0), (i <= 15 || i == 31) ? 1 : 0);
      check("pp_upper0", int'(upper0), (pp >= 8) ? 1 : 0);
      check("pp_tc0", int'(tc0), (i == 15 || i == 30) ? 1 : 0);
      advance();
    end

    // Loads, clamping, load beats enable, dir unchanged
    set_in(1'b1, 2'b00, 1'b1, 4, 4);
    settle(); check("ld_tc1", int'(tc1), 0); advance();
    check("ld4_q1", int'(q1), 4);
    set_in(1'b1, 2'b00, 1'b1, 9, 9);
    tick();
    check("ld9_q1", int'(q1), 9);
    check("ld9_dir1_kept", int'(dir1), 0);
    check("ld9_q0", int'(q0), 9);
    set_in(1'b1, 2'b00, 1'b1, 15, 20);
    tick();
    check("ld20_clamp_q1", int'(q1), 12);
    check("ld15_q0", int'(q0), 15);
    set_in(1'b1, 2'b00, 1'b1, 0, 1);
    tick();
    check("ld1_clamp_q1", int'(q1), 3);

    // Wrap-up over [3,12]
    set_in(1'b1, 2'b00, 1'b0, 0, 0);
    for (int j = 0; j < 11; j++) begin
      settle();
      check("up_q1", int'(q1), (j <= 9) ? 3 + j : 3);
      check("up_tc1", int'(tc1), (j == 9) ? 1 : 0);
      advance();
    end

    // Wrap-down from MIN
    set_in(1'b1, 2'b01, 1'b1, 0, 3);
    tick();
    set_in(1'b1, 2'b01, 1'b0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      settle();
      check("dn_q1", int'(q1), (j == 0) ? 3 : 13 - j);
      check("dn_tc1", int'(tc1), (j == 0) ? 1 : 0);
      if (j > 0) check("dn_dir1", int'(dir1), 0);
      advance();
    end

    // Enable low holds everything
    set_in(1'b1, 2'b01, 1'b1, 6, 6);
    tick();
    set_in(1'b0, 2'b01, 1'b0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      settle();
      check("en0_q1", int'(q1), 6);
      check("en0_tc1", int'(tc1), 0);
      check("en0_tc0", int'(tc0), 0);
      advance();
    end

    // Mode switch up -> down mid-count
    set_in(1'b1, 2'b00, 1'b1, 4, 4);
    tick();
    set_in(1'b1, 2'b00, 1'b0, 0, 0);
    tick();
    check("sw_up_q1", int'(q1), 5);
    check("sw_up_dir1", int'(dir1), 1);
    set_in(1'b1, 2'b01, 1'b0, 0, 0);
    tick();
    check("sw_dn_q1", int'(q1), 4);
    check("sw_dn_dir1", int'(dir1), 0);

    // Hold mode
    set_in(1'b1, 2'b11, 1'b0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      settle();
      check("hold_q1", int'(q1), 4);
      check("hold_tc1", int'(tc1), 0);
      advance();
    end

    // Async reset between edges at Q=11, dir=0
    set_in(1'b1, 2'b01, 1'b1, 12, 12);
    tick();
    set_in(1'b1, 2'b01, 1'b0, 0, 0);
    tick();
    check("pre_rst_q0", int'(q0), 11);
    check("pre_rst_dir0", int'(dir0), 0);
    set_in(1'b1, 2'b10, 1'b0, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_q0", int'(q0), 0);
    check("arst_dir0", int'(dir0), 1);
    check("arst_q1", int'(q1), 3);
    check("arst_dir1", int'(dir1), 1);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("post_rst_q0", int'(q0), k);
      check("post_rst_q1", int'(q1), 3 + k);
      advance();
    end

`ifdef PINGPONG_COUNTER_WRAPCNT_EN
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    set_in(1'b1, 2'b10, 1'b0, 0, 0);
    for (int j = 0; j < 46; j++) tick();
    check("wraps0_three", int'(wraps0), 3);
    set_in(1'b1, 2'b10, 1'b1, 5, 5);
    tick();
    check("wraps0_load_clr", int'(wraps0), 0);
    check("wraps1_load_clr", int'(wraps1), 0);
    set_in(1'b1, 2'b10, 1'b0, 0, 0);
    for (int j = 0; j < 4000; j++) tick();
    check("wraps0_sat", int'(wraps0), 255);
    check("wraps1_sat", int'(wraps1), 255);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
